bip_control: RTL and testbench

Control unit for the BIP processor; the instruction-side counterpart that drives the accumulator datapath.
- Sequences program-memory fetch through a program counter.
- Decodes the 5-bit opcode / 11-bit operand instruction word.
- Generates the datapath selects (selA, selB, wrAcc, op, operando) and the data-memory read/write strobes.
- Three-cycle multi-state FSM per instruction, started by a pulse and stopped by HLT.

---
 rtl/bip_control.sv | 171 +++++++++++++++++
 tb/tb_bip_control.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// BIP processor control unit: fetch/decode/execute sequencer
// driving the accumulator datapath and data-memory strobes.
module bip_control #(
    parameter int NB_ADDR     = 11,
    parameter int NB_OPCODE   = 5,
    parameter int NB_OPERANDO = 11,
    parameter int NB_DATA     = 16,
    parameter int NB_SEL_A    = 2,
    parameter int NB_COUNT    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_instruction,
    output logic [NB_ADDR-1:0]     o_pm_addr,
    output logic                   o_pm_en,
    output logic [NB_OPERANDO-1:0] o_ram_addr,
    output logic                   o_rdRam,
    output logic                   o_wrRam,
    output logic [NB_SEL_A-1:0]    o_selA,
    output logic                   o_selB,
    output logic                   o_wrAcc,
    output logic [NB_OPCODE-1:0]   o_op,
    output logic [NB_OPERANDO-1:0] o_operando,
    output logic                   o_halt,
    output logic [NB_COUNT-1:0]    o_inst_count
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    localparam logic [NB_SEL_A-1:0] SEL_MEM = NB_SEL_A'(0);
    localparam logic [NB_SEL_A-1:0] SEL_IMM = NB_SEL_A'(1);
    localparam logic [NB_SEL_A-1:0] SEL_ALU = NB_SEL_A'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NB_ADDR-1:0]     pc;
    logic [NB_DATA-1:0]     ir;
    logic [NB_COUNT-1:0]    count;
    logic [NB_COUNT-1:0]    count_inc;
    logic [NB_OPCODE-1:0]   pm_op;
    logic [NB_OPERANDO-1:0] pm_arg;
    logic [NB_OPCODE-1:0]   ir_op;
    logic [NB_OPERANDO-1:0] ir_arg;

    assign pm_op  = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign pm_arg = i_instruction[NB_OPERANDO-1:0];
    assign ir_op  = ir[NB_DATA-1 -: NB_OPCODE];
    assign ir_arg = ir[NB_OPERANDO-1:0];

    // Completed-instruction count sticks at all-ones instead of wrapping
    assign count_inc = (&count) ? count : count + NB_COUNT'(1);

    assign o_pm_addr    = pc;
    assign o_inst_count = count;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, instruction register and instruction counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc    <= '0;
            ir    <= '0;
            count <= '0;
        end else begin
            if (state == S_DECODE) begin
                ir <= i_instruction;
                if (pm_op == OP_HLT) begin
                    count <= count_inc;
                end
            end
            if (state == S_EXEC) begin
                pc    <= pc + NB_ADDR'(1);
                count <= count_inc;
            end
        end
    end

    // Next-state and datapath/strobe decode
    always_comb begin
        state_next = state;
        o_pm_en    = 1'b0;
        o_ram_addr = '0;
        o_rdRam    = 1'b0;
        o_wrRam    = 1'b0;
        o_selA     = '0;
        o_selB     = 1'b0;
        o_wrAcc    = 1'b0;
        o_op       = '0;
        o_operando = '0;
        o_halt     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_pm_en    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                o_ram_addr = pm_arg;
                // Memory operand is requested here so it is valid in EXEC
                o_rdRam = (pm_op == OP_LD) || (pm_op == OP_ADD)
                       || (pm_op == OP_SUB);
                if (pm_op == OP_HLT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                o_op       = ir_op;
                o_operando = ir_arg;
                o_ram_addr = ir_arg;
                state_next = S_FETCH;
                case (ir_op)
                    OP_STO: o_wrRam = 1'b1;
                    OP_LD: begin
                        o_selA  = SEL_MEM;
                        o_wrAcc = 1'b1;
                    end
                    OP_LDI: begin
                        o_selA  = SEL_IMM;
                        o_wrAcc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_selA  = SEL_ALU;
                        o_wrAcc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        o_selA  = SEL_ALU;
                        o_selB  = 1'b1;
                        o_wrAcc = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                o_halt = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: a program-level reference model
// predicts every strobe event; a negedge monitor compares them.
module tb_bip_control;

    typedef struct packed {
        int          cyc;
        logic        pm_en;
        logic [10:0] pm_addr;
        logic        rd;
        logic        wr;
        logic [10:0] ram_addr;
        logic        wacc;
        logic [1:0]  sela;
        logic        selb;
        logic [4:0]  op;
        logic [10:0] opnd;
    } ev_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_instruction = '0;
    logic [10:0] o_pm_addr;
    logic        o_pm_en;
    logic [10:0] o_ram_addr;
    logic        o_rdRam;
    logic        o_wrRam;
    logic [1:0]  o_selA;
    logic        o_selB;
    logic        o_wrAcc;
    logic [4:0]  o_op;
    logic [10:0] o_operando;
    logic        o_halt;
    logic [15:0] o_inst_count;

    always #5 i_clk = ~i_clk;

    bip_control dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_instruction(i_instruction),
        .o_pm_addr    (o_pm_addr),
        .o_pm_en      (o_pm_en),
        .o_ram_addr   (o_ram_addr),
        .o_rdRam      (o_rdRam),
        .o_wrRam      (o_wrRam),
        .o_selA       (o_selA),
        .o_selB       (o_selB),
        .o_wrAcc      (o_wrAcc),
        .o_op         (o_op),
        .o_operando   (o_operando),
        .o_halt       (o_halt),
        .o_inst_count (o_inst_count)
    );

    logic [15:0] pm    [2048];
    logic [15:0] mprog [2048];

    // Synchronous program memory
    always @(posedge i_clk) begin
        if (o_pm_en) i_instruction <= pm[o_pm_addr];
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state
    int m_pc, m_count, m_t, m_halt_cyc;
    bit m_halted;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int base);
        m_pc       = 0;
        m_count    = 0;
        m_t        = base + 1;
        m_halted   = 0;
        m_halt_cyc = -1;
    endtask

    // Executes up to n instructions of mprog, queueing every event
    task automatic model_run(input int n);
        ev_t         e;
        logic [15:0] w;
        int          opc;
        logic [10:0] arg;
        for (int i = 0; i < n && !m_halted; i++) begin
            w   = mprog[m_pc];
            opc = int'(w[15:11]);
            arg = w[10:0];
            e = '0;
            e.cyc = m_t; e.pm_en = 1'b1; e.pm_addr = 11'(m_pc);
            q.push_back(e);
            if (opc == 2 || opc == 4 || opc == 6) begin
                e = '0;
                e.cyc = m_t + 1; e.rd = 1'b1;
                e.pm_addr = 11'(m_pc); e.ram_addr = arg;
                q.push_back(e);
            end
            if (opc == 0) begin
                if (m_count < 65535) m_count++;
                m_halted   = 1;
                m_halt_cyc = m_t + 2;
            end else begin
                e = '0;
                e.cyc = m_t + 2; e.pm_addr = 11'(m_pc);
                e.ram_addr = arg; e.op = 5'(opc); e.opnd = arg;
                if (opc == 1) begin
                    e.wr = 1'b1;
                    q.push_back(e);
                end else if (opc >= 2 && opc <= 7) begin
                    e.wacc = 1'b1;
                    e.sela = (opc == 2) ? 2'd0 : (opc == 3) ? 2'd1 : 2'd2;
                    e.selb = (opc == 5 || opc == 7);
                    q.push_back(e);
                end
                m_pc = (m_pc + 1) % 2048;
                if (m_count < 65535) m_count++;
                m_t += 3;
            end
        end
    endtask

    // Monitor: any strobe cycle must match the next predicted event
    ev_t mo, mx;
    always @(negedge i_clk) begin
        if (o_pm_en || o_rdRam || o_wrRam || o_wrAcc) begin
            mo = '{cyc, o_pm_en, o_pm_addr, o_rdRam, o_wrRam,
                   o_ram_addr, o_wrAcc, o_selA, o_selB, o_op, o_operando};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cyc=%0d en=%0b pa=%0d rd=%0b wr=%0b ra=%0d wacc=%0b", mo.cyc, mo.pm_en, mo.pm_addr, mo.rd, mo.wr, mo.ram_addr, mo.wacc);
            end else begin
                mx = q.pop_front();
                if (mo !== mx) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d en=%0b pa=%0d rd=%0b wr=%0b ra=%0d wacc=%0b sa=%0d sb=%0b op=%0d od=%0d, expected cyc=%0d en=%0b pa=%0d rd=%0b wr=%0b ra=%0d wacc=%0b sa=%0d sb=%0b op=%0d od=%0d", mo.cyc, mo.pm_en, mo.pm_addr, mo.rd, mo.wr, mo.ram_addr, mo.wacc, mo.sela, mo.selb, mo.op, mo.opnd, mx.cyc, mx.pm_en, mx.pm_addr, mx.rd, mx.wr, mx.ram_addr, mx.wacc, mx.sela, mx.selb, mx.op, mx.opnd);
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) mprog[i] = 16'h0000;
    endtask

    task automatic do_reset();
        chk("queue_drained", q.size(), 0);
        q.delete();
        pm = mprog;
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic start(output int base);
        @(negedge i_clk);
        i_start = 1'b1;
        base    = cyc;
        model_reset(base);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_halt(input int bound, input bit noisy);
        int n;
        n = 0;
        while (!o_halt && n < bound) begin
            @(negedge i_clk);
            n++;
            if (noisy) i_start = ($urandom_range(0, 3) == 0);
        end
        i_start = 1'b0;
        chk("halt_reached", o_halt, 1);
        chk("halt_cycle", cyc, m_halt_cyc);
        chk("inst_count", o_inst_count, m_count);
        chk("halt_pc", o_pm_addr, m_pc);
    endtask

    task automatic halt_lock();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("halt_lock", {o_halt, o_pm_en}, 2);
        end
    endtask

    task automatic run_prog(input bit noisy);
        int base;
        do_reset();
        start(base);
        model_run(4096);
        wait_halt(300, noisy);
    endtask

    initial begin
        int base;
        int len;
        i_rst   = 1'b1;
        i_start = 1'b0;
        clear_prog();
        pm = mprog;

        // Reset and idle: everything quiet
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("idle_outputs",
                {o_pm_addr, o_pm_en, o_ram_addr, o_rdRam, o_wrRam,
                 o_selA, o_selB, o_wrAcc, o_op, o_operando, o_halt,
                 o_inst_count}, 0);
        end

        // Immediate program, then start pulses in HALT
        clear_prog();
        mprog[0] = 16'h1805;
        mprog[1] = 16'h2803;
        mprog[2] = 16'h0802;
        mprog[3] = 16'h0000;
        run_prog(1'b0);
        chk("imm_count", o_inst_count, 4);
        chk("imm_pc", o_pm_addr, 3);
        halt_lock();

        // Memory-operand program
        clear_prog();
        mprog[0] = 16'h1007;
        mprog[1] = 16'h3004;
        run_prog(1'b0);

        // Undefined opcode behaves as NOP
        clear_prog();
        mprog[0] = 16'hF8AA;
        run_prog(1'b0);

        // Reset during EXEC of ADDI, then a clean restart
        clear_prog();
        mprog[0] = 16'h1805;
        mprog[1] = 16'h2803;
        mprog[2] = 16'h0802;
        do_reset();
        start(base);
        model_run(2);
        for (int i = 0; i < 20 && cyc != base + 6; i++) @(negedge i_clk);
        chk("addi_exec_wacc", o_wrAcc, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_mid_wacc", o_wrAcc, 0);
        chk("rst_mid_state",
            {o_pm_en, o_halt, o_pm_addr, o_inst_count}, 0);
        @(negedge i_clk);
        chk("rst_mid_idle", {o_pm_en, o_op, o_selA}, 0);
        start(base);
        model_run(4096);
        wait_halt(300, 1'b1);

        // Random programs with stray start pulses during execution
        for (int it = 0; it < 10; it++) begin
            clear_prog();
            len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++) begin
                mprog[k] = {5'($urandom_range(1, 31)), 11'($urandom)};
            end
            run_prog(1'b1);
        end

        // PC wrap: 2048 NOPs, then HLT fetched again at address 0
        for (int i = 0; i < 2048; i++) begin
            mprog[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
        end
        do_reset();
        start(base);
        model_run(2048);
        mprog[0] = 16'h0000;
        model_run(10);
        repeat (10) @(negedge i_clk);
        pm[0] = 16'h0000;
        wait_halt(7000, 1'b0);
        chk("wrap_count", o_inst_count, 2049);
        chk("wrap_pc", o_pm_addr, 0);
        halt_lock();

        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
